// File: rtl/pipe_elastic_reg.sv
// Elastic valid/ready pipeline register built on a DEPTH-entry ring buffer; all outputs come from flops.
// Optional saturating stall counter enabled by defining PIPE_ELASTIC_STALL_CNT_EN.
module pipe_elastic_reg #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out_data,
  output logic [$clog2(DEPTH+1)-1:0]   count
`ifdef PIPE_ELASTIC_STALL_CNT_EN
  ,
  output logic [15:0]                  stall_cnt
`endif
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr, wr_nxt, rd_nxt;
  logic [CW-1:0]    count_nxt;
  logic [WIDTH-1:0] head_nxt;
  logic             push_c, pop_c;

  // Next-state for pointers, occupancy and the registered head entry
  always_comb begin
    push_c    = in_valid && in_ready && !flush;
    pop_c     = out_valid && out_ready && !flush;
    wr_nxt    = wr_ptr;
    rd_nxt    = rd_ptr;
    count_nxt = count;
    if (flush) begin
      wr_nxt    = '0;
      rd_nxt    = '0;
      count_nxt = '0;
    end else begin
      if (push_c) wr_nxt = wr_ptr + PW'(1);
      if (pop_c)  rd_nxt = rd_ptr + PW'(1);
      if (push_c && !pop_c)      count_nxt = count + CW'(1);
      else if (!push_c && pop_c) count_nxt = count - CW'(1);
    end
    // The word being written this cycle becomes the head when it lands at the next read slot
    head_nxt = (push_c && (wr_ptr == rd_nxt)) ? in_data : mem[rd_nxt];
  end

  // Storage; flush leaves contents untouched
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push_c) begin
      mem[wr_ptr] <= in_data;
    end
  end

  // Control and output registers; handshake outputs track the next occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      wr_ptr    <= wr_nxt;
      rd_ptr    <= rd_nxt;
      count     <= count_nxt;
      in_ready  <= (count_nxt != CW'(DEPTH));
      out_valid <= (count_nxt != '0);
      out_data  <= head_nxt;
    end
  end

`ifdef PIPE_ELASTIC_STALL_CNT_EN
  // Saturating count of cycles where the head is held back by the consumer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (flush) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_elastic_reg.sv
// Directed self-checking bench for pipe_elastic_reg with DEPTH=2 and DEPTH=4 instances.
module tb_pipe_elastic_reg;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush2, iv2, ir2, ov2, or2;
  logic [31:0] id2, od2;
  logic [1:0]  cnt2;
  logic        flush4, iv4, ir4, ov4, or4;
  logic [31:0] id4, od4;
  logic [2:0]  cnt4;
`ifdef PIPE_ELASTIC_STALL_CNT_EN
  logic [15:0] sc2, sc4;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pipe_elastic_reg #(.WIDTH(32), .DEPTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .flush(flush2),
    .in_valid(iv2), .in_ready(ir2), .in_data(id2),
    .out_valid(ov2), .out_ready(or2), .out_data(od2),
    .count(cnt2)
`ifdef PIPE_ELASTIC_STALL_CNT_EN
    , .stall_cnt(sc2)
`endif
  );

  pipe_elastic_reg #(.WIDTH(32), .DEPTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .flush(flush4),
    .in_valid(iv4), .in_ready(ir4), .in_data(id4),
    .out_valid(ov4), .out_ready(or4), .out_data(od4),
    .count(cnt4)
`ifdef PIPE_ELASTIC_STALL_CNT_EN
    , .stall_cnt(sc4)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int sent, rcv;
    rst_n = 1'b0;
    flush2 = 0; iv2 = 1; or2 = 0; id2 = 32'h1234;
    flush4 = 0; iv4 = 1; or4 = 0; id4 = 32'h5678;
    tick(); tick(); tick();
    rst_n = 1'b1;
    iv2 = 0; iv4 = 0;
    #1;
    chk("rst_in_ready2", 32'(ir2), 1);
    chk("rst_out_valid2", 32'(ov2), 0);
    chk("rst_count2", 32'(cnt2), 0);
    chk("rst_out_data2", od2, 0);
    chk("rst_in_ready4", 32'(ir4), 1);
    chk("rst_count4", 32'(cnt4), 0);
    tick();
    chk("rst_hold_valid2", 32'(ov2), 0);

    // Single transfer, one-cycle latency
    or2 = 1; iv2 = 1; id2 = 32'hA5A5_0001;
    tick();
    iv2 = 0;
    chk("lat_valid", 32'(ov2), 1);
    chk("lat_data", od2, 32'hA5A5_0001);
    chk("lat_count", 32'(cnt2), 1);
    tick();
    chk("pop_count", 32'(cnt2), 0);
    chk("pop_valid", 32'(ov2), 0);

    // DEPTH=4 fill under backpressure, then drain
    or4 = 0; iv4 = 1;
    for (int v = 1; v <= 5; v++) begin
      id4 = 32'(v);
      tick();
    end
    chk("full_count", 32'(cnt4), 4);
    chk("full_ready", 32'(ir4), 0);
    chk("full_head", od4, 1);
    or4 = 1;
    tick();
    chk("drain1_data", od4, 2);
    chk("drain1_count", 32'(cnt4), 3);
    chk("drain1_ready", 32'(ir4), 1);
    tick();
    iv4 = 0;
    chk("drain2_data", od4, 3);
    chk("drain2_count", 32'(cnt4), 3);
    tick();
    chk("drain3_data", od4, 4);
    tick();
    chk("drain4_data", od4, 5);
    chk("drain4_count", 32'(cnt4), 1);
    tick();
    chk("drain5_valid", 32'(ov4), 0);
    chk("drain5_count", 32'(cnt4), 0);
    or4 = 0;

    // Wrap-around stream with out_ready toggling
    sent = 0; rcv = 0; or2 = 0;
    for (int cyc = 0; cyc < 100 && rcv < 10; cyc++) begin
      iv2 = (sent < 10);
      id2 = 32'h10 + 32'(sent);
      or2 = ~or2;
      #1;
      if (ov2 && or2) begin
        chk("wrap_data", od2, 32'h10 + 32'(rcv));
        rcv++;
      end
      if (iv2 && ir2) sent++;
      tick();
    end
    iv2 = 0; or2 = 0;
    chk("wrap_received", 32'(rcv), 10);
    tick();
    chk("wrap_empty", 32'(ov2), 0);

    // Flush while full with a concurrent push attempt
    iv2 = 1; id2 = 32'h1; tick();
    id2 = 32'h2; tick();
    chk("pre_flush_count", 32'(cnt2), 2);
    flush2 = 1; id2 = 32'hDEAD;
    tick();
    flush2 = 0; iv2 = 0;
    chk("flush_count", 32'(cnt2), 0);
    chk("flush_valid", 32'(ov2), 0);
    tick();
    chk("flush_stays_empty", 32'(ov2), 0);

    // Flush with accepting push must discard it
    iv2 = 1; id2 = 32'h77; tick();
    flush2 = 1; id2 = 32'hDEAD; tick();
    flush2 = 0;
    chk("flush_push_count", 32'(cnt2), 0);
    id2 = 32'h88; or2 = 1; tick();
    iv2 = 0;
    chk("post_flush_data", od2, 32'h88);
    tick();
    chk("post_flush_count", 32'(cnt2), 0);
    or2 = 0;

`ifdef PIPE_ELASTIC_STALL_CNT_EN
    flush2 = 1; tick(); flush2 = 0;
    chk("stall_clear", 32'(sc2), 0);
    iv2 = 1; id2 = 32'h5; tick(); iv2 = 0;
    for (int i = 0; i < 5; i++) tick();
    chk("stall_five", 32'(sc2), 5);
    flush2 = 1; tick(); flush2 = 0;
    chk("stall_flush", 32'(sc2), 0);
    iv2 = 1; tick(); iv2 = 0;
    for (int i = 0; i < 70000; i++) tick();
    chk("stall_sat", 32'(sc2), 32'hFFFF);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pipe_elastic_reg.md
# pipe_elastic_reg

Parametrised elastic pipeline register that replaces the fixed enable/clear stage registers between pipeline stages. It carries a WIDTH-bit payload through a DEPTH-entry ring buffer using valid/ready handshakes. Producer backpressure is decoupled from consumer stalls without any combinational ready path. It sits between any two core stages (e.g. MEM→WB); `flush` gives the synchronous squash used on traps and branch redirects.

## Interface
- `WIDTH`, 32: payload width in bits, ≥1.
- `DEPTH`, 2: number of entries; power of two, 2..16.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `flush`  in  1  synchronous squash of all entries; overrides push and pop in the same cycle.
- `in_valid`  in  1  producer presents `in_data`.
- `in_ready`  out  1  buffer accepts a push this cycle.
- `in_data`  in  WIDTH  payload from the producer.
- `out_valid`  out  1  head entry is valid.
- `out_ready`  in  1  consumer accepts the head entry.
- `out_data`  out  WIDTH  head entry payload.
- `count`  out  $clog2(DEPTH+1)  number of occupied entries.
- `stall_cnt`  out  16  present only with `PIPE_ELASTIC_STALL_CNT_EN` (see Configuration).

## Operation
- State:
  - storage array `mem[DEPTH]` of WIDTH bits;
  - `wr_ptr` and `rd_ptr`, each $clog2(DEPTH) bits, wrapping naturally modulo DEPTH;
  - `count` register.
- Push occurs when `in_valid && in_ready && !flush`:
  - `mem[wr_ptr] <= in_data`;
  - `wr_ptr` increments.
- Pop occurs when `out_valid && out_ready && !flush`:
  - `rd_ptr` increments.
- Count update:
  - push only: +1;
  - pop only: −1;
  - both, or neither: unchanged.
- `in_ready = (count != DEPTH)`. It is derived from the registered count only and never depends on `out_ready`.
- `out_valid = (count != 0)`; `out_data = mem[rd_ptr]`.
- Full with `out_ready=1`: `in_ready` stays 0 that cycle (no same-cycle refill). Pop proceeds, and `in_ready` rises the next cycle.
- Empty: `out_valid=0`. `out_ready` is ignored and pointers stay put.
- Flush:
  - next state is `count=0` and `wr_ptr=rd_ptr=0`;
  - `mem` contents are left unchanged;
  - a concurrent push is discarded and a concurrent pop is not counted.
- The producer must hold `in_data` stable while `in_valid && !in_ready`.
- The block itself never drops or reorders data except on flush; order is strict FIFO.

## Timing
- Reset (async assert, sync-to-clock release by the top level):
  - `count=0`, `wr_ptr=rd_ptr=0`, all `mem` entries 0;
  - `out_valid=0`, `out_data=0`, `in_ready=1`, `stall_cnt=0`.
- Reset mid-operation aborts in-flight entries immediately; no partial push survives.
- Latency: a push at edge N makes `out_valid=1` with that payload visible after edge N (one cycle). There is no combinational in→out path.
- Throughput: one transfer per cycle sustained while `0 < count < DEPTH`.
- With DEPTH=2, a full-rate stream continues at 1/cycle under a single-cycle `out_ready` bubble.
- Every output is a function of registers only; there is no input→output combinational path.

## Configuration
- `PIPE_ELASTIC_STALL_CNT_EN` defined:
  - `stall_cnt` is a 16-bit register that increments each cycle with `out_valid && !out_ready`;
  - it saturates at 0xFFFF;
  - it clears to 0 on reset and on `flush`.
- Not defined: the `stall_cnt` port and its register are absent; all other behaviour is identical.

## Test plan
- Reset with `in_valid=1` during reset → after release `in_ready=1`, `out_valid=0`, `count=0`, `out_data=0`.
- WIDTH=32, DEPTH=2, push 0xA5A5_0001 at edge 1 with `out_ready=1` → `out_valid=1` and `out_data=0xA5A5_0001` after edge 1. Popped at edge 2; `count` returns to 0.
- DEPTH=4, `out_ready=0`, push 0x1..0x5 back-to-back:
  - 4 accepted, `in_ready=0` with `count=4`, value 0x5 held;
  - raise `out_ready` → pops 0x1,0x2,0x3,0x4,0x5 in order; `in_ready` rises one cycle after the first pop.
- Wrap-around: DEPTH=2, stream 10 words 0x10..0x19 with `out_ready` toggling every cycle → all 10 delivered in order, none duplicated.
- Flush with `count=2` and simultaneous push of 0xDEAD → next cycle `count=0` and `out_valid=0`; 0xDEAD is never delivered.
- Macro defined, `out_valid=1`, `out_ready=0` for 5 cycles → `stall_cnt=5`. `flush` → 0. Forcing 70000 stall cycles → holds 0xFFFF.
